ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Parametrised EX/MEM pipeline stage for the MIPS pipeline. It carries the memory/write-back control bits, store data, ALU result and destination register from the execute stage to the memory stage. Unlike a plain capture register, it adds a valid/ready handshake (stall), synchronous flush (bubble insertion), an optional skid entry that breaks the `out_ready → in_ready` combinational path, and a forwarding tap for the hazard unit.

## Interface
Parameters:
- `DATA_W`, 8: width of ALU result and store data.
- `REG_ADDR_W`, 3: width of destination register index.
- `SKID_EN`, 1: 1 = two-entry skid (registered `in_ready`); 0 = single entry, `in_ready = !out_valid || out_ready`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous kill of all held and incoming entries.
- `in_valid` in 1: EX presents an instruction.
- `in_ready` out 1: stage accepts this cycle.
- `in_mem_read`, `in_mem_write`, `in_mem_to_reg`, `in_reg_write` in 1 each: control bits.
- `in_store_data` in `DATA_W`: rt value for stores.
- `in_alu_out` in `DATA_W`: ALU result / address.
- `in_reg_dst` in `REG_ADDR_W`: write-back register.
- `out_valid` out 1; `out_ready` in 1: MEM-side handshake.
- `out_mem_read`, `out_mem_write`, `out_mem_to_reg`, `out_reg_write` out 1 each.
- `out_store_data`, `out_alu_out` out `DATA_W`; `out_reg_dst` out `REG_ADDR_W`.
- `fwd_valid` out 1: `out_valid && out_reg_write && !out_mem_to_reg`.
- `fwd_reg_dst` out `REG_ADDR_W`; `fwd_data` out `DATA_W` (= `out_reg_dst`, `out_alu_out`).
- `occupancy` out 2: number of held entries (0..2; max 1 when `SKID_EN=0`).

## Operation
- Input transfer when `in_valid && in_ready`; output transfer when `out_valid && out_ready`.
- Entries: main (drives outputs) and skid (used only when `SKID_EN=1`).
- States: EMPTY (occ 0), ONE (main valid), FULL (main + skid valid).
  - EMPTY: input transfer → ONE.
  - ONE:
    - input without output → FULL (input goes to skid);
    - input with output → ONE (main reloaded);
    - output only → EMPTY.
  - FULL: `in_ready=0`; output transfer → ONE (skid moves to main, skid cleared).
- With `SKID_EN=0`, the FULL state does not exist.
- `in_ready` (`SKID_EN=1`) = `!skid_valid`, taken from a register only.
- Order is strictly FIFO; no entry is dropped or duplicated.
- Bubble rule: any entry that is not valid holds all control bits at 0. `out_mem_*`/`out_reg_write` are 0 whenever `out_valid=0`. Data fields of an invalid entry are don't-care but are cleared on flush/reset.
- `flush`: next edge clears main and skid (→ EMPTY). A simultaneous input transfer is discarded, and the simultaneous output transfer still counts as consumed. Flush has priority over every other event.
- Fields are copied unmodified; no arithmetic. Widths are exact per parameters.

## Timing
- Reset (async, immediate): `out_valid=0`, all `out_*`=0, `fwd_valid=0`, `fwd_*`=0, `occupancy=0`, `in_ready=1`. Reset mid-transfer discards all entries.
- Latency: `in` accepted at edge N → visible on `out_*` after edge N (one cycle) when the stage is empty or draining.
- Throughput: one instruction per cycle with `out_ready=1`.
- `SKID_EN=1`: `out_ready` deasserting costs one skid slot. `in_ready` falls one cycle after the skid fills and rises the cycle after it drains.
- All outputs except `in_ready` (`SKID_EN=0`) and `fwd_*` are registered. `fwd_*` is combinational from registered outputs only.

## Structure
- Package `ex_mem_pkg`:
  - typedef `mem_ctrl_t` struct {`mem_read`, `mem_write`, `mem_to_reg`, `reg_write`};
  - constant `MEM_CTRL_NOP` (all zero);
  - default widths `DATA_W_DEF=8`, `REG_ADDR_W_DEF=3`.
- Sub-module `pipe_slot`: one entry (valid, ctrl, data, dst) with load/clear inputs. Instantiated twice (main, skid); the skid instance is generated only when `SKID_EN=1`.

## Test plan
- Reset: assert `rst` mid-stream with occ=2 → immediately `out_valid=0`, controls 0, `occupancy=0`, `in_ready=1`.
- Streaming: `out_ready=1`, send alu_out 0x11,0x22,0x33 with dst 1,2,3 → same values appear on consecutive cycles, each one cycle later.
- Stall (`SKID_EN=1`): `out_ready=0`, send 0xA1, 0xA2 → occ=2 and `in_ready=0`. Then `out_ready=1` → 0xA1 then 0xA2 out, with `in_ready=1` after the first drain.
- Flush: occ=2 with `in_valid=1` (0x55) and `flush=1` → next cycle occ=0, `out_valid=0`, all controls 0, 0x55 never emitted.
- Forwarding: entry `reg_write=1`, `mem_to_reg=0`, dst=5, alu=0x7E → `fwd_valid=1`, `fwd_reg_dst=5`, `fwd_data=0x7E`. Same entry with `mem_to_reg=1` → `fwd_valid=0`.
- `SKID_EN=0`, `DATA_W=32`: `out_ready=0`, `out_valid=1` → `in_ready=0` same cycle. Raise `out_ready` → `in_ready=1` same cycle, and a 32-bit value 0xDEADBEEF passes intact.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared types and defaults for the EX/MEM pipeline stage.
// Control bundle carried from execute to memory/write-back.
package ex_mem_pkg;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } mem_ctrl_t;

  localparam mem_ctrl_t MEM_CTRL_NOP = '0;

  localparam int DATA_W_DEF     = 8;
  localparam int REG_ADDR_W_DEF = 3;

endpackage

// File: rtl/ex_mem_stage_pipe_slot.sv
// One EX/MEM entry: valid, control, store data, ALU result, dst.
// Clear wins over load; an invalid entry always holds a NOP control.
module pipe_slot
  import ex_mem_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  mem_ctrl_t             d_ctrl,
  input  logic [DATA_W-1:0]     d_store_data,
  input  logic [DATA_W-1:0]     d_alu_out,
  input  logic [REG_ADDR_W-1:0] d_reg_dst,
  output logic                  valid,
  output mem_ctrl_t             ctrl,
  output logic [DATA_W-1:0]     store_data,
  output logic [DATA_W-1:0]     alu_out,
  output logic [REG_ADDR_W-1:0] reg_dst
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid      <= 1'b0;
      ctrl       <= MEM_CTRL_NOP;
      store_data <= '0;
      alu_out    <= '0;
      reg_dst    <= '0;
    end else if (clear) begin
      valid      <= 1'b0;
      ctrl       <= MEM_CTRL_NOP;
      store_data <= '0;
      alu_out    <= '0;
      reg_dst    <= '0;
    end else if (load) begin
      valid      <= 1'b1;
      ctrl       <= d_ctrl;
      store_data <= d_store_data;
      alu_out    <= d_alu_out;
      reg_dst    <= d_reg_dst;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM stage: valid/ready handshake, flush, optional skid entry,
// and a forwarding tap taken from the registered main entry.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter bit SKID_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic                  in_mem_to_reg,
  input  logic                  in_reg_write,
  input  logic [DATA_W-1:0]     in_store_data,
  input  logic [DATA_W-1:0]     in_alu_out,
  input  logic [REG_ADDR_W-1:0] in_reg_dst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  out_mem_to_reg,
  output logic                  out_reg_write,
  output logic [DATA_W-1:0]     out_store_data,
  output logic [DATA_W-1:0]     out_alu_out,
  output logic [REG_ADDR_W-1:0] out_reg_dst,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_reg_dst,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [1:0]            occupancy
);

  mem_ctrl_t             in_ctrl;
  mem_ctrl_t             main_ctrl;
  mem_ctrl_t             skid_ctrl;
  logic                  main_valid;
  logic                  skid_valid;
  logic [DATA_W-1:0]     skid_store_data;
  logic [DATA_W-1:0]     skid_alu_out;
  logic [REG_ADDR_W-1:0] skid_reg_dst;

  logic                  in_xfer;
  logic                  out_xfer;
  logic                  main_from_skid;
  logic                  main_load;
  logic                  main_clr;
  mem_ctrl_t             main_d_ctrl;
  logic [DATA_W-1:0]     main_d_store_data;
  logic [DATA_W-1:0]     main_d_alu_out;
  logic [REG_ADDR_W-1:0] main_d_reg_dst;

  assign in_ctrl = '{
    mem_read:   in_mem_read,
    mem_write:  in_mem_write,
    mem_to_reg: in_mem_to_reg,
    reg_write:  in_reg_write
  };

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_valid && out_ready;

  // Main refills from skid first to keep FIFO order.
  assign main_from_skid = skid_valid && out_xfer;
  assign main_load = main_from_skid
                  || (in_xfer && (!main_valid || out_xfer));
  assign main_clr  = flush || (out_xfer && !main_load);

  always_comb begin
    main_d_ctrl       = in_ctrl;
    main_d_store_data = in_store_data;
    main_d_alu_out    = in_alu_out;
    main_d_reg_dst    = in_reg_dst;
    if (main_from_skid) begin
      main_d_ctrl       = skid_ctrl;
      main_d_store_data = skid_store_data;
      main_d_alu_out    = skid_alu_out;
      main_d_reg_dst    = skid_reg_dst;
    end
  end

  pipe_slot #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_main (
    .clk          (clk),
    .rst          (rst),
    .clear        (main_clr),
    .load         (main_load),
    .d_ctrl       (main_d_ctrl),
    .d_store_data (main_d_store_data),
    .d_alu_out    (main_d_alu_out),
    .d_reg_dst    (main_d_reg_dst),
    .valid        (main_valid),
    .ctrl         (main_ctrl),
    .store_data   (out_store_data),
    .alu_out      (out_alu_out),
    .reg_dst      (out_reg_dst)
  );

  if (SKID_EN) begin : g_skid
    pipe_slot #(
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W)
    ) u_skid (
      .clk          (clk),
      .rst          (rst),
      .clear        (flush || main_from_skid),
      .load         (in_xfer && main_valid && !out_xfer),
      .d_ctrl       (in_ctrl),
      .d_store_data (in_store_data),
      .d_alu_out    (in_alu_out),
      .d_reg_dst    (in_reg_dst),
      .valid        (skid_valid),
      .ctrl         (skid_ctrl),
      .store_data   (skid_store_data),
      .alu_out      (skid_alu_out),
      .reg_dst      (skid_reg_dst)
    );
    assign in_ready = !skid_valid;
  end else begin : g_no_skid
    assign skid_valid      = 1'b0;
    assign skid_ctrl       = MEM_CTRL_NOP;
    assign skid_store_data = '0;
    assign skid_alu_out    = '0;
    assign skid_reg_dst    = '0;
    assign in_ready        = !main_valid || out_ready;
  end

  assign out_valid      = main_valid;
  assign out_mem_read   = main_ctrl.mem_read;
  assign out_mem_write  = main_ctrl.mem_write;
  assign out_mem_to_reg = main_ctrl.mem_to_reg;
  assign out_reg_write  = main_ctrl.reg_write;

  assign fwd_valid   = main_valid && main_ctrl.reg_write
                    && !main_ctrl.mem_to_reg;
  assign fwd_reg_dst = out_reg_dst;
  assign fwd_data    = out_alu_out;

  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus random traffic
// against a queue model, on a skid build and a 32-bit no-skid build.
module tb_ex_mem_stage;

  typedef struct packed {
    logic [3:0]  c;
    logic [31:0] sd;
    logic [31:0] alu;
    logic [2:0]  dst;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  ent_t qa[$];
  ent_t qb[$];

  // DUT A: DATA_W=8, skid on. c = {mem_read,mem_write,mem_to_reg,reg_write}
  logic       a_fl = 0, a_iv = 0, a_ordy = 0;
  logic [3:0] a_ic = 0;
  logic [7:0] a_sd = 0, a_alu = 0;
  logic [2:0] a_dst = 0;
  logic       a_ir, a_ov, a_omr, a_omw, a_omtr, a_orw, a_fv;
  logic [7:0] a_osd, a_oalu, a_fdata;
  logic [2:0] a_odst, a_fdst;
  logic [1:0] a_occ;

  ex_mem_stage #(.DATA_W(8), .REG_ADDR_W(3), .SKID_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .flush(a_fl),
    .in_valid(a_iv), .in_ready(a_ir),
    .in_mem_read(a_ic[3]), .in_mem_write(a_ic[2]),
    .in_mem_to_reg(a_ic[1]), .in_reg_write(a_ic[0]),
    .in_store_data(a_sd), .in_alu_out(a_alu), .in_reg_dst(a_dst),
    .out_valid(a_ov), .out_ready(a_ordy),
    .out_mem_read(a_omr), .out_mem_write(a_omw),
    .out_mem_to_reg(a_omtr), .out_reg_write(a_orw),
    .out_store_data(a_osd), .out_alu_out(a_oalu), .out_reg_dst(a_odst),
    .fwd_valid(a_fv), .fwd_reg_dst(a_fdst), .fwd_data(a_fdata),
    .occupancy(a_occ)
  );

  // DUT B: DATA_W=32, no skid.
  logic        b_fl = 0, b_iv = 0, b_ordy = 0;
  logic [3:0]  b_ic = 0;
  logic [31:0] b_sd = 0, b_alu = 0;
  logic [2:0]  b_dst = 0;
  logic        b_ir, b_ov, b_omr, b_omw, b_omtr, b_orw, b_fv;
  logic [31:0] b_osd, b_oalu, b_fdata;
  logic [2:0]  b_odst, b_fdst;
  logic [1:0]  b_occ;

  ex_mem_stage #(.DATA_W(32), .REG_ADDR_W(3), .SKID_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .flush(b_fl),
    .in_valid(b_iv), .in_ready(b_ir),
    .in_mem_read(b_ic[3]), .in_mem_write(b_ic[2]),
    .in_mem_to_reg(b_ic[1]), .in_reg_write(b_ic[0]),
    .in_store_data(b_sd), .in_alu_out(b_alu), .in_reg_dst(b_dst),
    .out_valid(b_ov), .out_ready(b_ordy),
    .out_mem_read(b_omr), .out_mem_write(b_omw),
    .out_mem_to_reg(b_omtr), .out_reg_write(b_orw),
    .out_store_data(b_osd), .out_alu_out(b_oalu), .out_reg_dst(b_odst),
    .fwd_valid(b_fv), .fwd_reg_dst(b_fdst), .fwd_data(b_fdata),
    .occupancy(b_occ)
  );

  task automatic drive_a(input logic v, input logic [3:0] c,
                         input logic [7:0] alu, input logic [2:0] dst,
                         input logic ordy, input logic fl);
    @(negedge clk);
    a_iv = v; a_ic = c; a_alu = alu; a_sd = ~alu; a_dst = dst;
    a_ordy = ordy; a_fl = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    drive_a(0, 4'h0, 8'h00, 3'd0, 1'b1, 1'b0);
    tick();
    tick();
  endtask

  task automatic test_reset();
    drive_a(1, 4'hF, 8'hC1, 3'd6, 1'b0, 1'b0);
    tick();
    drive_a(1, 4'hF, 8'hC2, 3'd7, 1'b0, 1'b0);
    tick();
    n_tests++;
    if (a_occ !== 2'd2) begin
      n_fail++; $display("FAIL reset_pre_occ: got %0d expected 2", a_occ);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({a_ov, a_omr, a_omw, a_omtr, a_orw, a_fv} !== 6'b0 ||
        a_occ !== 2'd0 || a_ir !== 1'b1 || a_oalu !== 8'h00 ||
        a_odst !== 3'd0 || a_fdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async: ov=%b ctl=%b%b%b%b occ=%0d ir=%b alu=%h expected 0/0000/0/1/00",
               a_ov, a_omr, a_omw, a_omtr, a_orw, a_occ, a_ir, a_oalu);
    end
    a_iv = 0;
    #2 rst = 1'b0;
    qa.delete();
    qb.delete();
  endtask

  task automatic test_stream();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      drive_a(1, 4'h1, vals[i], 3'(i + 1), 1'b1, 1'b0);
      tick();
      n_tests++;
      if (a_ov !== 1'b1 || a_oalu !== vals[i] || a_odst !== 3'(i + 1) ||
          a_occ !== 2'd1) begin
        n_fail++;
        $display("FAIL stream_%0d: ov=%b alu=%h dst=%0d occ=%0d expected 1/%h/%0d/1",
                 i, a_ov, a_oalu, a_odst, a_occ, vals[i], i + 1);
      end
    end
    drive_a(0, 4'h0, 8'h00, 3'd0, 1'b1, 1'b0);
    tick();
    n_tests++;
    if (a_ov !== 1'b0 || a_occ !== 2'd0) begin
      n_fail++; $display("FAIL stream_end: ov=%b occ=%0d expected 0/0", a_ov, a_occ);
    end
  endtask

  task automatic test_stall();
    drive_a(1, 4'h8, 8'hA1, 3'd1, 1'b0, 1'b0);
    tick();
    n_tests++;
    if (a_occ !== 2'd1 || a_ir !== 1'b1 || a_oalu !== 8'hA1) begin
      n_fail++;
      $display("FAIL stall_one: occ=%0d ir=%b alu=%h expected 1/1/a1", a_occ, a_ir, a_oalu);
    end
    drive_a(1, 4'h4, 8'hA2, 3'd2, 1'b0, 1'b0);
    tick();
    n_tests++;
    if (a_occ !== 2'd2 || a_ir !== 1'b0 || a_oalu !== 8'hA1) begin
      n_fail++;
      $display("FAIL stall_full: occ=%0d ir=%b alu=%h expected 2/0/a1", a_occ, a_ir, a_oalu);
    end
    drive_a(0, 4'h0, 8'h00, 3'd0, 1'b1, 1'b0);
    tick();
    n_tests++;
    if (a_ov !== 1'b1 || a_oalu !== 8'hA2 || a_omw !== 1'b1 ||
        a_omr !== 1'b0 || a_ir !== 1'b1 || a_occ !== 2'd1) begin
      n_fail++;
      $display("FAIL stall_drain1: ov=%b alu=%h mw=%b ir=%b occ=%0d expected 1/a2/1/1/1",
               a_ov, a_oalu, a_omw, a_ir, a_occ);
    end
    tick();
    n_tests++;
    if (a_ov !== 1'b0 || a_occ !== 2'd0 || a_omw !== 1'b0) begin
      n_fail++; $display("FAIL stall_drain2: ov=%b occ=%0d expected 0/0", a_ov, a_occ);
    end
  endtask

  task automatic test_flush();
    drive_a(1, 4'hF, 8'h31, 3'd1, 1'b0, 1'b0);
    tick();
    drive_a(1, 4'hF, 8'h32, 3'd2, 1'b0, 1'b0);
    tick();
    drive_a(1, 4'hF, 8'h55, 3'd5, 1'b1, 1'b1);
    tick();
    n_tests++;
    if (a_occ !== 2'd0 || a_ov !== 1'b0 || {a_omr, a_omw, a_omtr, a_orw} !== 4'h0 ||
        a_oalu !== 8'h00 || a_fv !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: occ=%0d ov=%b ctl=%b%b%b%b alu=%h expected 0/0/0000/00",
               a_occ, a_ov, a_omr, a_omw, a_omtr, a_orw, a_oalu);
    end
    drive_a(0, 4'h0, 8'h00, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (a_ov !== 1'b0 || a_occ !== 2'd0) begin
        n_fail++;
        $display("FAIL flush_after_%0d: ov=%b alu=%h expected no output", i, a_ov, a_oalu);
      end
    end
  endtask

  task automatic test_fwd();
    drive_a(1, 4'h1, 8'h7E, 3'd5, 1'b0, 1'b0);
    tick();
    n_tests++;
    if (a_fv !== 1'b1 || a_fdst !== 3'd5 || a_fdata !== 8'h7E) begin
      n_fail++;
      $display("FAIL fwd_alu: fv=%b dst=%0d data=%h expected 1/5/7e", a_fv, a_fdst, a_fdata);
    end
    drive_a(1, 4'h3, 8'h7E, 3'd5, 1'b1, 1'b0);
    tick();
    n_tests++;
    if (a_fv !== 1'b0 || a_ov !== 1'b1 || a_omtr !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd_load: fv=%b ov=%b mtr=%b expected 0/1/1", a_fv, a_ov, a_omtr);
    end
    idle_a();
  endtask

  task automatic test_no_skid();
    @(negedge clk);
    b_iv = 1; b_ic = 4'h1; b_alu = 32'hDEADBEEF; b_sd = 32'h01234567;
    b_dst = 3'd4; b_ordy = 0; b_fl = 0;
    tick();
    @(negedge clk);
    b_iv = 1; b_alu = 32'hCAFEF00D; b_dst = 3'd3;
    #1;
    n_tests++;
    if (b_ov !== 1'b1 || b_ir !== 1'b0 || b_occ !== 2'd1) begin
      n_fail++;
      $display("FAIL noskid_block: ov=%b ir=%b occ=%0d expected 1/0/1", b_ov, b_ir, b_occ);
    end
    b_ordy = 1;
    #1;
    n_tests++;
    if (b_ir !== 1'b1 || b_oalu !== 32'hDEADBEEF || b_osd !== 32'h01234567) begin
      n_fail++;
      $display("FAIL noskid_pass: ir=%b alu=%h sd=%h expected 1/deadbeef/01234567",
               b_ir, b_oalu, b_osd);
    end
    tick();
    n_tests++;
    if (b_ov !== 1'b1 || b_oalu !== 32'hCAFEF00D || b_odst !== 3'd3) begin
      n_fail++;
      $display("FAIL noskid_next: ov=%b alu=%h dst=%0d expected 1/cafef00d/3", b_ov, b_oalu, b_odst);
    end
    @(negedge clk);
    b_iv = 0;
    tick();
    tick();
  endtask

  task automatic test_random_a();
    ent_t e, h;
    logic v, o, f, exp_ir, exp_fv;
    @(negedge clk);
    a_iv = 0; a_fl = 1; a_ordy = 0;
    tick();
    qa.delete();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      v = 1'($urandom_range(0, 1));
      o = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 29) == 0);
      e.c = 4'($urandom); e.sd = {24'h0, 8'($urandom)};
      e.alu = {24'h0, 8'($urandom)}; e.dst = 3'($urandom);
      a_iv = v; a_ic = e.c; a_sd = e.sd[7:0]; a_alu = e.alu[7:0];
      a_dst = e.dst; a_ordy = o; a_fl = f;
      exp_ir = (qa.size() < 2);
      #1;
      n_tests++;
      if (a_ir !== exp_ir) begin
        n_fail++; $display("FAIL rand_a_ready[%0d]: got %b expected %b", i, a_ir, exp_ir);
      end
      @(posedge clk);
      if (f) qa.delete();
      else begin
        if (qa.size() > 0 && o) void'(qa.pop_front());
        if (v && exp_ir) qa.push_back(e);
      end
      #1;
      n_tests++;
      if (qa.size() == 0) begin
        if (a_ov !== 1'b0 || {a_omr, a_omw, a_omtr, a_orw} !== 4'h0 ||
            a_occ !== 2'd0 || a_fv !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_a_empty[%0d]: ov=%b ctl=%b%b%b%b occ=%0d expected bubble",
                   i, a_ov, a_omr, a_omw, a_omtr, a_orw, a_occ);
        end
      end else begin
        h = qa[0];
        exp_fv = h.c[0] && !h.c[1];
        if (a_ov !== 1'b1 || {a_omr, a_omw, a_omtr, a_orw} !== h.c ||
            a_oalu !== h.alu[7:0] || a_osd !== h.sd[7:0] || a_odst !== h.dst ||
            a_occ !== 2'(qa.size()) || a_fv !== exp_fv ||
            a_fdata !== h.alu[7:0] || a_fdst !== h.dst) begin
          n_fail++;
          $display("FAIL rand_a_head[%0d]: ctl=%b%b%b%b alu=%h sd=%h dst=%0d occ=%0d fv=%b expected %b %h %h %0d %0d %b",
                   i, a_omr, a_omw, a_omtr, a_orw, a_oalu, a_osd, a_odst, a_occ, a_fv,
                   h.c, h.alu[7:0], h.sd[7:0], h.dst, qa.size(), exp_fv);
        end
      end
    end
    idle_a();
  endtask

  task automatic test_random_b();
    ent_t e, h;
    logic v, o, f, exp_ir;
    @(negedge clk);
    b_iv = 0; b_fl = 1; b_ordy = 0;
    tick();
    qb.delete();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      v = 1'($urandom_range(0, 1));
      o = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 29) == 0);
      e.c = 4'($urandom); e.sd = $urandom; e.alu = $urandom; e.dst = 3'($urandom);
      b_iv = v; b_ic = e.c; b_sd = e.sd; b_alu = e.alu;
      b_dst = e.dst; b_ordy = o; b_fl = f;
      exp_ir = (qb.size() == 0) || o;
      #1;
      n_tests++;
      if (b_ir !== exp_ir) begin
        n_fail++; $display("FAIL rand_b_ready[%0d]: got %b expected %b", i, b_ir, exp_ir);
      end
      @(posedge clk);
      if (f) qb.delete();
      else begin
        if (qb.size() > 0 && o) void'(qb.pop_front());
        if (v && exp_ir) qb.push_back(e);
      end
      #1;
      n_tests++;
      if (qb.size() == 0) begin
        if (b_ov !== 1'b0 || {b_omr, b_omw, b_omtr, b_orw} !== 4'h0 ||
            b_occ !== 2'd0 || b_fv !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_b_empty[%0d]: ov=%b occ=%0d expected bubble", i, b_ov, b_occ);
        end
      end else begin
        h = qb[0];
        if (b_ov !== 1'b1 || {b_omr, b_omw, b_omtr, b_orw} !== h.c ||
            b_oalu !== h.alu || b_osd !== h.sd || b_odst !== h.dst ||
            b_occ !== 2'(qb.size()) || b_fv !== (h.c[0] && !h.c[1])) begin
          n_fail++;
          $display("FAIL rand_b_head[%0d]: ctl=%b%b%b%b alu=%h dst=%0d occ=%0d expected %b %h %0d %0d",
                   i, b_omr, b_omw, b_omtr, b_orw, b_oalu, b_odst, b_occ,
                   h.c, h.alu, h.dst, qb.size());
        end
      end
    end
  endtask

  initial begin
    #12 rst = 1'b0;
    idle_a();
    test_reset();
    idle_a();
    test_stream();
    idle_a();
    test_stall();
    idle_a();
    test_flush();
    idle_a();
    test_fwd();
    test_no_skid();
    test_random_a();
    test_random_b();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
